// File: rtl/reg_bus_scan_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// | Module   : reg_bus_scan_sequencer_pkg                                    |
// | Purpose  : Shared definitions for the register-bus scan sequencer:      |
// |            FSM state encoding and index-width helper.                    |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
package reg_bus_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GAP     = 2'd1,
    DRIVE   = 2'd2,
    PRESENT = 2'd3
  } scan_state_t;

  // Width of a register index; never below one bit so a single-register
  // bus still has a legal index port.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bus_scan_sequencer_cs_decoder.sv
`default_nettype none
// ============================================================================
// | Module   : reg_bus_cs_decoder                                            |
// | Purpose  : Registered one-hot-low chip-select decoder. All selects high |
// |            (register outputs high-Z) whenever enable is low.             |
// | Ports    : Clock, Reset (async, active-high), idx, enable -> cs          |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
module reg_bus_cs_decoder #(
  parameter int NrOfRegs = 8,
  parameter int IdxW     = 3
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [IdxW-1:0]     idx,
  input  logic                enable,
  output logic [NrOfRegs-1:0] cs
);

  logic [NrOfRegs-1:0] cs_next;

  always_comb begin
    cs_next = '1;
    for (int i = 0; i < NrOfRegs; i++) begin
      if (enable && (idx == IdxW'(i))) cs_next[i] = 1'b0;
    end
  end

  // Registering the decode keeps cs free of decoder glitches.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) cs <= '1;
    else       cs <= cs_next;
  end

endmodule
`default_nettype wire

// File: rtl/reg_bus_scan_sequencer.sv
`default_nettype none
// ============================================================================
// | Module   : reg_bus_scan_sequencer                                        |
// | Purpose  : Scans a tri-state register bank one register at a time,      |
// |            samples each value off the shared bus and presents it as a    |
// |            valid/ready stream. Break-before-make on the bus.             |
// | Ports    : Clock, Reset, Tick, Start, BusIn -> Cs                         |
// |            OutData/OutIndex/OutValid, OutReady, Busy, Done               |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
module reg_bus_scan_sequencer
  import reg_bus_scan_sequencer_pkg::*;
#(
  parameter int NrOfRegs         = 8,
  parameter int NrOfBits         = 8,
  parameter int TurnaroundCycles = 1,
  localparam int IdxW            = idx_width(NrOfRegs)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                Start,
  input  logic [NrOfBits-1:0] BusIn,
  output logic [NrOfRegs-1:0] Cs,
  output logic [NrOfBits-1:0] OutData,
  output logic [IdxW-1:0]     OutIndex,
  output logic                OutValid,
  input  logic                OutReady,
  output logic                Busy,
  output logic                Done
);

  localparam logic [3:0]      GapInit = (TurnaroundCycles == 0) ? 4'd0 : 4'(TurnaroundCycles - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NrOfRegs - 1);
  // Entry state of every word slot: skip GAP entirely without turnaround.
  localparam scan_state_t     FirstState = (TurnaroundCycles == 0) ? DRIVE : GAP;

  scan_state_t     state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [3:0]      gap_q, gap_d;
  logic            load_word;
  logic            clear_valid;
  logic            set_done;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    load_word   = 1'b0;
    clear_valid = 1'b0;
    set_done    = 1'b0;
    if (Tick) begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            idx_d   = '0;
            gap_d   = GapInit;
            state_d = FirstState;
          end
        end
        GAP: begin
          if (gap_q == 4'd0) state_d = DRIVE;
          else               gap_d   = gap_q - 4'd1;
        end
        DRIVE: begin
          load_word = 1'b1;
          state_d   = PRESENT;
        end
        PRESENT: begin
          if (OutReady) begin
            clear_valid = 1'b1;
            if (idx_q == LastIdx) begin
              set_done = 1'b1;
              state_d  = IDLE;
            end else begin
              idx_d   = idx_q + IdxW'(1);
              gap_d   = GapInit;
              state_d = FirstState;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      OutData  <= '0;
      OutIndex <= '0;
      OutValid <= 1'b0;
      Done     <= 1'b0;
    end else begin
      // Done is a single-Clock pulse, independent of Tick.
      Done <= set_done;
      if (load_word) begin
        OutData  <= BusIn;
        OutIndex <= idx_q;
        OutValid <= 1'b1;
      end else if (clear_valid) begin
        OutValid <= 1'b0;
      end
    end
  end

  assign Busy = (state_q != IDLE);

  // Decoding from the next state makes Cs line up with state_q exactly.
  // DRIVE always exits to PRESENT (all high), so two selects can never
  // be low in consecutive cycles.
  reg_bus_cs_decoder #(
    .NrOfRegs(NrOfRegs),
    .IdxW    (IdxW)
  ) u_cs_decoder (
    .Clock (Clock),
    .Reset (Reset),
    .idx   (idx_d),
    .enable(state_d == DRIVE),
    .cs    (Cs)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_scan_sequencer.sv
`default_nettype none
// ============================================================================
// | Module   : tb_reg_bus_scan_sequencer                                     |
// | Purpose  : Directed self-checking bench for reg_bus_scan_sequencer.      |
// |            Four instances: (4 regs,T=1), (4,T=0), (4,T=3), (5,T=1).       |
// | Ports    : none                                                           |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
module tb_reg_bus_scan_sequencer;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic tick  = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b1;
  logic tick_div3 = 1'b0;
  int   phase = 0;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] vals4 = {32'h0, 32'h44332211};
  localparam logic [63:0] vals5 = {24'h0, 40'hA5A4A3A2A1};

  logic [15:0] exp4 [4] = '{16'h0011, 16'h0122, 16'h0233, 16'h0344};
  logic [15:0] exp5 [5] = '{16'h00A1, 16'h01A2, 16'h02A3, 16'h03A4, 16'h04A5};

  // Bus model: value of the selected register, high-Z when nobody drives.
  function automatic logic [7:0] resolve(input logic [7:0] cs_n, input logic [63:0] vals);
    logic [7:0] r;
    r = 8'hzz;
    for (int i = 0; i < 8; i++) if (!cs_n[i]) r = vals[i*8 +: 8];
    return r;
  endfunction

  logic [3:0] cs_a, cs_b, cs_c;
  logic [4:0] cs_d;
  logic [7:0] data_a, data_b, data_c, data_d;
  logic [1:0] idx_a, idx_b, idx_c;
  logic [2:0] idx_d;
  logic valid_a, valid_b, valid_c, valid_d;
  logic busy_a, busy_b, busy_c, busy_d;
  logic done_a, done_b, done_c, done_d;
  logic [7:0] bus_a, bus_b, bus_c, bus_d;

  assign bus_a = resolve({4'hF, cs_a}, vals4);
  assign bus_b = resolve({4'hF, cs_b}, vals4);
  assign bus_c = resolve({4'hF, cs_c}, vals4);
  assign bus_d = resolve({3'h7, cs_d}, vals5);

  reg_bus_scan_sequencer #(.NrOfRegs(4), .NrOfBits(8), .TurnaroundCycles(1)) dut_a (
    .Clock(clk), .Reset(rst), .Tick(tick), .Start(start), .BusIn(bus_a), .Cs(cs_a),
    .OutData(data_a), .OutIndex(idx_a), .OutValid(valid_a), .OutReady(ready),
    .Busy(busy_a), .Done(done_a));

  reg_bus_scan_sequencer #(.NrOfRegs(4), .NrOfBits(8), .TurnaroundCycles(0)) dut_b (
    .Clock(clk), .Reset(rst), .Tick(tick), .Start(start), .BusIn(bus_b), .Cs(cs_b),
    .OutData(data_b), .OutIndex(idx_b), .OutValid(valid_b), .OutReady(ready),
    .Busy(busy_b), .Done(done_b));

  reg_bus_scan_sequencer #(.NrOfRegs(4), .NrOfBits(8), .TurnaroundCycles(3)) dut_c (
    .Clock(clk), .Reset(rst), .Tick(tick), .Start(start), .BusIn(bus_c), .Cs(cs_c),
    .OutData(data_c), .OutIndex(idx_c), .OutValid(valid_c), .OutReady(ready),
    .Busy(busy_c), .Done(done_c));

  reg_bus_scan_sequencer #(.NrOfRegs(5), .NrOfBits(8), .TurnaroundCycles(1)) dut_d (
    .Clock(clk), .Reset(rst), .Tick(tick), .Start(start), .BusIn(bus_d), .Cs(cs_d),
    .OutData(data_d), .OutIndex(idx_d), .OutValid(valid_d), .OutReady(ready),
    .Busy(busy_d), .Done(done_d));

  always #5 clk = ~clk;

  // Tick is updated just after each rising edge, either constant 1 or
  // one pulse every third Clock.
  always @(posedge clk) begin
    #1;
    if (tick_div3) begin
      tick  = (phase == 2);
      phase = (phase == 2) ? 0 : phase + 1;
    end else begin
      tick  = 1'b1;
      phase = 0;
    end
  end

  // Monitor on the falling edge: inputs and outputs are all settled, and
  // tick/ready/valid here are what the next rising edge will see.
  logic [15:0] q_a[$];
  logic [15:0] q_d[$];
  int          t_a[$];
  int          cyc = 0;
  int          done_cnt_a = 0, done_cnt_d = 0;
  int          cs_viol = 0, stab_viol = 0, freeze_viol = 0, busx_viol = 0;
  logic        hold_a = 1'b0, hold_d = 1'b0, was_tick0 = 1'b0;
  logic [9:0]  held_a, held_d;
  logic [15:0] snap;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hold_a    = 1'b0;
      hold_d    = 1'b0;
      was_tick0 = 1'b0;
    end else begin
      if (tick && ready && valid_a) begin
        q_a.push_back({6'b0, idx_a, data_a});
        t_a.push_back(cyc);
      end
      if (tick && ready && valid_d) q_d.push_back({5'b0, idx_d, data_d});
      if (done_a) done_cnt_a++;
      if (done_d) done_cnt_d++;
      if ($countones(~cs_a) > 1 || $countones(~cs_b) > 1 ||
          $countones(~cs_c) > 1 || $countones(~cs_d) > 1) cs_viol++;
      if ((cs_a != 4'hF && $isunknown(bus_a)) || (cs_d != 5'h1F && $isunknown(bus_d))) busx_viol++;
      if (hold_a && (!valid_a || {idx_a, data_a} != held_a)) stab_viol++;
      if (hold_d && (!valid_d || {idx_d[1:0], data_d} != held_d)) stab_viol++;
      hold_a = valid_a && !(ready && tick);
      hold_d = valid_d && !(ready && tick);
      held_a = {idx_a, data_a};
      held_d = {idx_d[1:0], data_d};
      if (was_tick0 && {cs_a, valid_a, busy_a, idx_a, data_a} != snap[15:0]) freeze_viol++;
      was_tick0 = !tick;
      snap = {cs_a, valid_a, busy_a, idx_a, data_a};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic clear_mon;
    q_a.delete();
    q_d.delete();
    t_a.delete();
    done_cnt_a = 0;
    done_cnt_d = 0;
  endtask

  task automatic pulse_start(input int len);
    start = 1'b1;
    step(len);
    start = 1'b0;
  endtask

  task automatic wait_done_a(input int limit);
    int k;
    k = 0;
    while (done_cnt_a == 0 && k < limit) begin
      step(1);
      k++;
    end
    step(3);
  endtask

  task automatic check_words_a(input string tag);
    check($sformatf("%s_count", tag), q_a.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < q_a.size()) check($sformatf("%s_word%0d", tag, i), q_a[i], exp4[i]);
    check($sformatf("%s_done", tag), done_cnt_a, 1);
  endtask

  initial begin
    int k, lat_b, lat_c, gap_err, stall_err;
    logic [3:0] cs_c_drive, cs_b_first;

    // Test 1: reset state, then a plain scan of 4 registers with T=1.
    do_reset;
    check("rst_cs", cs_a, 4'hF);
    check("rst_valid", valid_a, 1'b0);
    check("rst_data", data_a, 8'h00);
    check("rst_idx", idx_a, 2'd0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    clear_mon();
    ready = 1'b1;
    pulse_start(1);
    wait_done_a(60);
    check_words_a("t1");
    for (int i = 1; i < 4; i++)
      if (i < t_a.size()) check($sformatf("t1_spacing%0d", i), t_a[i] - t_a[i-1], 3);
    check("t1_busy_end", busy_a, 1'b0);

    // Test 2: consumer stalls for 10 cycles on word 1.
    do_reset;
    clear_mon();
    ready = 1'b1;
    pulse_start(1);
    k = 0;
    while (!(valid_a && idx_a == 2'd1) && k < 20) begin
      step(1);
      k++;
    end
    ready = 1'b0;
    stall_err = 0;
    repeat (10) begin
      step(1);
      if (valid_a !== 1'b1 || data_a !== 8'h22 || cs_a !== 4'hF || idx_a !== 2'd1) stall_err++;
    end
    check("t2_stall_err", stall_err, 0);
    check("t2_stall_data", data_a, 8'h22);
    ready = 1'b1;
    wait_done_a(60);
    check_words_a("t2");

    // Test 3: Tick every third Clock; same words, frozen on Tick=0 edges.
    do_reset;
    clear_mon();
    freeze_viol = 0;
    tick_div3 = 1'b1;
    step(3);
    pulse_start(3);
    wait_done_a(200);
    check_words_a("t3");
    check("t3_freeze", freeze_viol, 0);
    tick_div3 = 1'b0;
    step(3);

    // Test 4: first-word latency for T=0 and T=3, selects high in GAP.
    do_reset;
    clear_mon();
    lat_b = 0;
    lat_c = 0;
    gap_err = 0;
    cs_c_drive = 4'h0;
    cs_b_first = 4'h0;
    start = 1'b1;
    for (int kk = 1; kk <= 10; kk++) begin
      step(1);
      start = 1'b0;
      if (kk == 1) cs_b_first = cs_b;
      if (valid_b && lat_b == 0) lat_b = kk;
      if (valid_c && lat_c == 0) lat_c = kk;
      if (kk <= 3 && cs_c !== 4'hF) gap_err++;
      if (kk == 4) cs_c_drive = cs_c;
    end
    // kk counts edges including the Start-accept edge.
    check("t4_lat_t0", lat_b - 1, 1);
    check("t4_lat_t3", lat_c - 1, 4);
    check("t4_gap_cs", gap_err, 0);
    check("t4_cs_drive_t3", cs_c_drive, 4'hE);
    check("t4_cs_drive_t0", cs_b_first, 4'hE);

    // Test 5: reset while register 2 drives, then a fresh scan.
    do_reset;
    clear_mon();
    start = 1'b1;
    k = 0;
    while (cs_a !== 4'hB && k < 30) begin
      step(1);
      start = 1'b0;
      k++;
    end
    check("t5_reach_cs2", cs_a, 4'hB);
    rst = 1'b1;
    #1;
    check("t5_rst_cs", cs_a, 4'hF);
    check("t5_rst_valid", valid_a, 1'b0);
    check("t5_rst_busy", busy_a, 1'b0);
    step(1);
    rst = 1'b0;
    step(1);
    clear_mon();
    pulse_start(1);
    wait_done_a(60);
    check_words_a("t5");

    // Test 6: Start pulsed mid-scan on a 5-register bus is ignored.
    do_reset;
    clear_mon();
    ready = 1'b1;
    pulse_start(1);
    k = 0;
    while (!(valid_d && idx_d == 3'd2) && k < 40) begin
      step(1);
      k++;
    end
    pulse_start(1);
    k = 0;
    while (done_cnt_d == 0 && k < 60) begin
      step(1);
      k++;
    end
    step(10);
    check("t6_count", q_d.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < q_d.size()) check($sformatf("t6_word%0d", i), q_d[i], exp5[i]);
    check("t6_done", done_cnt_d, 1);
    check("t6_busy_end", busy_d, 1'b0);

    // Invariants accumulated over the whole run.
    check("cs_onehot", cs_viol, 0);
    check("data_stable", stab_viol, 0);
    check("bus_known", busx_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
